// File: rtl/draw_line_if.sv
// Request/pixel bundle for the draw_line block: endpoints and enables in,
// current pixel and line status out.
interface draw_line_if #(
    parameter int CORDW = 16
);
    logic                    start_i;
    logic                    oe_i;
    logic signed [CORDW-1:0] x0_i;
    logic signed [CORDW-1:0] y0_i;
    logic signed [CORDW-1:0] x1_i;
    logic signed [CORDW-1:0] y1_i;
    logic signed [CORDW-1:0] x_o;
    logic signed [CORDW-1:0] y_o;
    logic                    drawing_o;
    logic                    busy_o;
    logic                    done_o;

    modport master (
        output start_i, oe_i, x0_i, y0_i, x1_i, y1_i,
        input  x_o, y_o, drawing_o, busy_o, done_o
    );

    modport slave (
        input  start_i, oe_i, x0_i, y0_i, x1_i, y1_i,
        output x_o, y_o, drawing_o, busy_o, done_o
    );
endinterface

// File: rtl/draw_line.sv
// Bresenham line rasteriser for all octants: one pixel per enabled cycle,
// always walking from the endpoint with the smaller y towards the larger.
module draw_line #(
    parameter int CORDW = 16
) (
    input  logic         clk,
    input  logic         reset_i,
    draw_line_if.slave   bus
);
    localparam int W1 = CORDW + 1;
    localparam int W2 = CORDW + 2;
    localparam int W3 = CORDW + 3;
    localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

    typedef enum logic [1:0] {IDLE, INIT, DRAW} state_t;

    state_t                  state_q;
    logic signed [CORDW-1:0] xa_q, ya_q, xb_q, yb_q;
    logic signed [CORDW-1:0] x_q, y_q;
    logic signed [W1-1:0]    dx_q, dy_q;
    logic signed [W2-1:0]    err_q;
    logic                    right_q, busy_q, done_q;

    logic                    swap;
    logic signed [CORDW-1:0] xa_s, ya_s, xb_s, yb_s;
    logic signed [W1-1:0]    xdiff_s, dx_s, dy_s;
    logic                    right_s;

    // NOTE: every combinational output gets a value before any condition, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        swap    = bus.y0_i > bus.y1_i;
        xa_s    = swap ? bus.x1_i : bus.x0_i;
        ya_s    = swap ? bus.y1_i : bus.y0_i;
        xb_s    = swap ? bus.x0_i : bus.x1_i;
        yb_s    = swap ? bus.y0_i : bus.y1_i;
        xdiff_s = {xb_s[CORDW-1], xb_s} - {xa_s[CORDW-1], xa_s};
        dx_s    = xdiff_s[W1-1] ? -xdiff_s : xdiff_s;
        dy_s    = {ya_s[CORDW-1], ya_s} - {yb_s[CORDW-1], yb_s};
        right_s = xa_s < xb_s;
    end

    logic signed [W3-1:0]    e2, dx_w, dy_w;
    logic                    movx, movy, at_end;
    logic signed [W2-1:0]    err_d;
    logic signed [CORDW-1:0] x_d, y_d;

    // Error term is widened so 2*err never wraps against dx/dy extremes.
    always_comb begin
        e2     = {err_q, 1'b0};
        dx_w   = {{2{dx_q[W1-1]}}, dx_q};
        dy_w   = {{2{dy_q[W1-1]}}, dy_q};
        movx   = e2 >= dy_w;
        movy   = e2 <= dx_w;
        err_d  = err_q + (movx ? {dy_q[W1-1], dy_q} : '0)
                       + (movy ? {dx_q[W1-1], dx_q} : '0);
        x_d    = x_q;
        if (movx) x_d = right_q ? x_q + ONE : x_q - ONE;
        y_d    = movy ? y_q + ONE : y_q;
        at_end = (x_q == xb_q) && (y_q == yb_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            xa_q    <= '0;
            ya_q    <= '0;
            xb_q    <= '0;
            yb_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            right_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        xa_q    <= xa_s;
                        ya_q    <= ya_s;
                        xb_q    <= xb_s;
                        yb_q    <= yb_s;
                        dx_q    <= dx_s;
                        dy_q    <= dy_s;
                        right_q <= right_s;
                        busy_q  <= 1'b1;
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    err_q   <= {dx_q[W1-1], dx_q} + {dy_q[W1-1], dy_q};
                    x_q     <= xa_q;
                    y_q     <= ya_q;
                    state_q <= DRAW;
                end
                DRAW: begin
                    if (bus.oe_i) begin
                        if (at_end) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            x_q   <= x_d;
                            y_q   <= y_d;
                            err_q <= err_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.x_o       = x_q;
    assign bus.y_o       = y_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.drawing_o = (state_q == DRAW) && bus.oe_i;
endmodule

// File: tb/tb_draw_line.sv
// Scoreboard bench for draw_line: a reference rasteriser fills the expected
// pixel queue, a negedge monitor drains it as the DUT emits pixels.
module tb_draw_line;
    localparam int CW = 12;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    draw_line_if #(.CORDW(CW)) bus ();
    draw_line #(.CORDW(CW)) dut (.clk(clk), .reset_i(reset_i), .bus(bus));

    typedef struct {
        bit done;
        int x;
        int y;
        int n;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   rand_oe = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rasteriser on plain integers.
    task automatic push_line(input int x0, input int y0, input int x1, input int y1);
        int xa, ya, xb, yb, dx, dy, err, x, y, e2, n;
        bit right, mx, my;
        if (y0 > y1) begin xa = x1; ya = y1; xb = x0; yb = y0; end
        else         begin xa = x0; ya = y0; xb = x1; yb = y1; end
        right = xa < xb;
        dx    = right ? xb - xa : xa - xb;
        dy    = ya - yb;
        err   = dx + dy;
        x = xa; y = ya; n = 0;
        while (n < 10000) begin
            sb.push_back('{1'b0, x, y, 0});
            n++;
            if (x == xb && y == yb) break;
            e2 = 2 * err;
            mx = e2 >= dy;
            my = e2 <= dx;
            if (mx) x += right ? 1 : -1;
            if (my) y++;
            err += (mx ? dy : 0) + (my ? dx : 0);
        end
        sb.push_back('{1'b1, 0, 0, ((dx > -dy) ? dx : -dy) + 1});
    endtask

    // Monitor: compares every presented pixel and done pulse against the queue.
    int   line_cnt = 0;
    bit   expect_done = 1'b0;
    bit   seen = 1'b0;
    bit   prev_stall = 1'b0;
    int   prev_x = 0, prev_y = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset_i) begin
            line_cnt = 0; expect_done = 0; seen = 0; prev_stall = 0;
        end else begin
            if (bus.done_o) begin
                check("done_expected", int'(sb.size() > 0 && sb[0].done), 1);
                if (sb.size() > 0 && sb[0].done) begin
                    e = sb.pop_front();
                    check("done_timing", int'(expect_done), 1);
                    check("pixel_count", line_cnt, e.n);
                    check("busy_at_done", int'(bus.busy_o), 0);
                end
                line_cnt = 0; seen = 0; prev_stall = 0;
            end else if (expect_done) begin
                check("done_missing", int'(bus.done_o), 1);
            end
            expect_done = 0;
            if (!bus.oe_i) check("drawing_gated", int'(bus.drawing_o), 0);
            if (bus.drawing_o) begin
                check("pixel_expected", int'(sb.size() > 0 && !sb[0].done), 1);
                if (sb.size() > 0 && !sb[0].done) begin
                    e = sb.pop_front();
                    check("pixel_x", int'(bus.x_o), e.x);
                    check("pixel_y", int'(bus.y_o), e.y);
                    check("busy_drawing", int'(bus.busy_o), 1);
                    if (sb.size() > 0 && sb[0].done) expect_done = 1;
                end
                line_cnt++;
                seen = 1;
            end
            if (seen && bus.busy_o && !bus.drawing_o && prev_stall) begin
                check("stall_hold_x", int'(bus.x_o), prev_x);
                check("stall_hold_y", int'(bus.y_o), prev_y);
            end
            prev_stall = seen && bus.busy_o && !bus.drawing_o;
            prev_x = int'(bus.x_o);
            prev_y = int'(bus.y_o);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_oe) bus.oe_i = ($urandom_range(0, 3) != 0);
    end

    task automatic scramble();
        bus.x0_i = CW'($urandom); bus.y0_i = CW'($urandom);
        bus.x1_i = CW'($urandom); bus.y1_i = CW'($urandom);
    endtask

    task automatic launch(input int x0, input int y0, input int x1, input int y1);
        bus.x0_i = CW'(x0); bus.y0_i = CW'(y0);
        bus.x1_i = CW'(x1); bus.y1_i = CW'(y1);
        bus.start_i = 1'b1;
        push_line(x0, y0, x1, y1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        scramble();
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset_i = 1'b1;
        sb.delete();
        #1;
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_drawing", int'(bus.drawing_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_x", int'(bus.x_o), 0);
        check("rst_y", int'(bus.y_o), 0);
        @(posedge clk);
        #3;
        reset_i = 1'b0;
    endtask

    task automatic draw(input int x0, input int y0, input int x1, input int y1,
                        input bit stall, input bit poke);
        int budget;
        launch(x0, y0, x1, y1);
        budget = 4 * sb.size() + 50;
        if (stall) begin
            repeat (3) @(posedge clk);
            #1 bus.oe_i = 1'b0;
            repeat (2) @(posedge clk);
            #1 bus.oe_i = 1'b1;
        end
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 bus.start_i = 1'b1;
            @(posedge clk);
            #1 bus.start_i = 1'b0;
        end
        for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            check("line_timeout", sb.size(), 0);
            apply_reset();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.oe_i    = 1'b1;
        bus.x0_i = '0; bus.y0_i = '0; bus.x1_i = '0; bus.y1_i = '0;
        #1;
        check("init_busy", int'(bus.busy_o), 0);
        check("init_drawing", int'(bus.drawing_o), 0);
        check("init_x", int'(bus.x_o), 0);
        repeat (2) @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1;

        draw(0, 0, 3, 0, 0, 0);
        draw(2, 5, 0, 1, 0, 0);
        draw(0, 0, 4, 2, 0, 0);
        draw(5, 5, 5, 5, 0, 0);
        draw(0, 0, 3, 3, 1, 0);
        draw(0, 0, 10, 3, 0, 1);

        // Abort a line part-way, then confirm a clean restart.
        launch(0, 0, 20, 7);
        repeat (6) @(posedge clk);
        apply_reset();
        draw(-3, 4, 7, -2, 0, 0);
        draw(-2048, -2048, 2047, 2047, 0, 0);
        draw(-2048, 0, 2047, 1, 0, 0);
        draw(2047, 2047, 2047, 2047, 0, 0);

        rand_oe = 1'b1;
        for (int i = 0; i < 40; i++) begin
            draw(int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60,
                 int'($urandom_range(0, 120)) - 60, int'($urandom_range(0, 120)) - 60,
                 0, 0);
        end
        rand_oe = 1'b0;
        bus.oe_i = 1'b1;
        repeat (5) @(posedge clk);
        check("queue_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/draw_line.md
DRAW_LINE -- requirements
Module: draw_line

Interface
REQ-001 CORDW, default 16, coordinate width in bits (signed two's complement); the codebase instantiates it with 12.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset_i  input  1  reset, asynchronous, active-high.
REQ-004 start_i  input  1  start request, sampled only in IDLE.
REQ-005 oe_i  input  1  output enable; low stalls drawing with no state change.
REQ-006 x0_i, y0_i  input  CORDW signed  endpoint 0.
REQ-007 x1_i, y1_i  input  CORDW signed  endpoint 1.
REQ-008 x_o, y_o  output  CORDW signed  current pixel coordinate.
REQ-009 drawing_o  output  1  x_o/y_o is a valid pixel this cycle.
REQ-010 busy_o  output  1  request accepted and not yet complete.
REQ-011 done_o  output  1  line complete; high for exactly one cycle.

Function
REQ-012 The FSM SHALL have the states IDLE, INIT and DRAW (Bresenham, all octants).
REQ-013 In IDLE with start_i=1: if y0_i>y1_i, the endpoints SHALL be swapped so drawing runs from the endpoint with the smaller y to the larger; otherwise (xa,ya)=(x0,y0) and (xb,yb)=(x1,y1).
REQ-014 On the same start edge: right=(xa<xb); dx=|xb-xa|; dy=ya-yb (≤0), both CORDW+1 signed; busy_o<=1; next state INIT.
REQ-015 INIT (one cycle, unconditional): err<=dx+dy (CORDW+2 signed); x<=xa; y<=ya; next state DRAW.
REQ-016 drawing_o SHALL be combinational: 1 iff state==DRAW and oe_i=1.
REQ-017 In DRAW with oe_i=1 and (x,y)==(xb,yb): the current pixel SHALL be output; next state IDLE, busy_o<=0, done_o<=1.
REQ-018 In DRAW with oe_i=1 and not at the end, with e2=2*err:
- movx = (e2>=dy); movy = (e2<=dx).
- If movx: x steps +1 when right=1, else -1.
- If movy: y steps +1.
- err <= err + (movx ? dy : 0) + (movy ? dx : 0).
REQ-019 In DRAW with oe_i=0, x, y, err and state SHALL hold.
REQ-020 done_o SHALL default to 0 every cycle; it is set only per REQ-017.
REQ-021 A line SHALL emit exactly max(|dx|,|dy|)+1 pixels, each with drawing_o=1 for one enabled cycle, starting at (xa,ya) and ending at (xb,yb).
REQ-022 start_i asserted while busy SHALL be ignored; inputs are latched only at start.
REQ-023 Latency: start sampled at edge E0 -> INIT after E0 -> DRAW after E1; the first pixel is valid in the cycle after E1 when oe_i=1.
REQ-024 A zero-length line (endpoints equal) SHALL emit one pixel, then assert done.

Reset
REQ-025 reset_i SHALL force state=IDLE and busy_o=0, done_o=0, x_o=0, y_o=0 immediately, independent of clk, including mid-line; drawing_o is then 0.
REQ-026 After reset release, the first start_i SHALL start a fresh line with no residue from the previous one.

Verification
REQ-027 (0,0)->(3,0), oe_i=1 -> pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles; done_o pulses one cycle after (3,0); busy_o falls at the same edge.
REQ-028 (2,5)->(0,1) -> swap; first pixel (0,1), last pixel (2,5); exactly 5 pixels; y increments every pixel.
REQ-029 (0,0)->(4,2) -> pixels (0,0),(1,0)|(1,1),…,(4,2); 5 pixels; x strictly increasing; y non-decreasing.
REQ-030 (5,5)->(5,5) -> a single pixel (5,5), then a done_o pulse.
REQ-031 (0,0)->(3,3) with oe_i low for 2 cycles after the 2nd pixel -> drawing_o=0 and x_o/y_o held during the stall; the sequence resumes at (2,2); 4 pixels total.
REQ-032 Assert reset_i mid-line -> busy_o=0 and drawing_o=0 immediately; no done_o pulse; a subsequent start draws the new line correctly.
